// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcode and func3 codes, write-back
// source select, load/store unit FSM states and instruction classification.
// No ports (package).
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Major opcodes, instruction[6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  // Load func3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store func3 codes
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_MEM} wb_sel_e;

  typedef enum logic {IDLE, RESP_WAIT} lsu_state_e;

  typedef struct packed {
    logic    is_load;
    logic    is_store;
    logic    writes;
    wb_sel_e wb_sel;
  } op_class_t;

  // Map a major opcode to its memory/write-back behaviour.
  function automatic op_class_t classify(input logic [4:0] opcode);
    op_class_t c;
    c = '{is_load: 1'b0, is_store: 1'b0, writes: 1'b0, wb_sel: WB_ALU};
    case (opcode)
      OP_LOAD:  begin c.is_load = 1'b1; c.writes = 1'b1; c.wb_sel = WB_MEM; end
      OP_STORE: c.is_store = 1'b1;
      OP_IMM, OP_REG, OP_LUI, OP_AUIPC: c.writes = 1'b1;
      OP_JAL, OP_JALR: begin c.writes = 1'b1; c.wb_sel = WB_PC4; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/halfword addressed by addr_i out of the
// bus word and sign- or zero-extends it according to the load func3.
// Ports: rdata_i   - 32-bit load data word from the bus
//        addr_i    - low two bits of the effective address
//        func3_i   - load func3 (undefined codes behave as LW)
//        ldata_c_o - extended 32-bit value (combinational)
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] ldata_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (func3_i)
      F3_LB:   ldata_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ldata_c_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ldata_c_o = {24'd0, byte_sel};
      F3_LHU:  ldata_c_o = {16'd0, half_sel};
      default: ldata_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// Memory/write-back stage of the three-stage RISC-V pipeline. Issues loads and
// stores on a valid/ready data bus, produces the register-file write-back and
// stalls the upstream pipeline registers while an access is outstanding.
// Ports: clk/rst                     - clock, synchronous active-high reset
//        PC_ppl, ALU_ppl, rdata2_ppl, instruction_ppl - execute-stage registers
//        dbus_req/we/addr/wdata/be   - bus request (combinational)
//        dbus_ready/rvalid/rdata     - bus handshake and load response
//        reg_wr, wdata               - register-file write-back (combinational)
//        mem_stall                   - hold upstream registers (combinational)
//        misalign, bus_timeout       - registered one-cycle event pulses
module mem_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_ppl,
  input  logic [XLEN-1:0] ALU_ppl,
  input  logic [XLEN-1:0] rdata2_ppl,
  input  logic [XLEN-1:0] instruction_ppl,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_ready,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            reg_wr,
  output logic [XLEN-1:0] wdata,
  output logic            mem_stall,
  output logic            misalign,
  output logic            bus_timeout
);

  localparam int unsigned    CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The response is abandoned in the TIMEOUT-th RESP_WAIT cycle.
  localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT - 1);
  localparam logic            TimeoutEn = (TIMEOUT != 0);

  lsu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            misalign_q, misalign_d;
  logic            bus_timeout_q, bus_timeout_d;

  logic [4:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      func3;
  op_class_t       cls;
  logic            mem_op;
  logic            rd_nz;
  logic            is_byte, is_half, is_word;
  logic            misal;
  logic            timeout_hit;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_value;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      lane_be;
  logic            unused_ins;

  // Instruction decode
  assign opcode     = instruction_ppl[6:2];
  assign rd         = instruction_ppl[11:7];
  assign func3      = instruction_ppl[14:12];
  assign cls        = classify(opcode);
  assign mem_op     = cls.is_load | cls.is_store;
  assign rd_nz      = |rd;
  assign unused_ins = ^{instruction_ppl[31:15], instruction_ppl[1:0]};

  // Access size; undefined func3 codes fall back to a word access
  assign is_byte = cls.is_load ? (func3 == F3_LB || func3 == F3_LBU) : (func3 == F3_SB);
  assign is_half = cls.is_load ? (func3 == F3_LH || func3 == F3_LHU) : (func3 == F3_SH);
  assign is_word = ~is_byte & ~is_half;
  assign misal   = (is_half & ALU_ppl[0]) | (is_word & (|ALU_ppl[1:0]));

  // Store lane replication and byte enables
  assign st_wdata = is_byte ? {4{rdata2_ppl[7:0]}} :
                    is_half ? {2{rdata2_ppl[15:0]}} : rdata2_ppl;
  assign lane_be  = is_byte ? (4'b0001 << ALU_ppl[1:0]) :
                    is_half ? (4'b0011 << ALU_ppl[1:0]) : 4'b1111;

  load_align u_load_align (
    .rdata_i   (dbus_rdata),
    .addr_i    (ALU_ppl[1:0]),
    .func3_i   (func3),
    .ldata_c_o (load_val)
  );

  always_comb begin
    case (cls.wb_sel)
      WB_PC4:  wb_value = PC_ppl + 32'd4;
      WB_MEM:  wb_value = load_val;
      default: wb_value = ALU_ppl;
    endcase
  end

  // rvalid takes priority over an expiring timeout in the same cycle
  assign timeout_hit = TimeoutEn && (state_q == RESP_WAIT) && !dbus_rvalid &&
                       (cnt_q == CntLast);

  // State, counter and event-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      misalign_q    <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      misalign_q    <= misalign_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    misalign_d    = 1'b0;
    bus_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          if (misal) begin
            misalign_d = 1'b1;
          end else if (cls.is_load && dbus_ready && !dbus_rvalid) begin
            state_d = RESP_WAIT;
          end
        end
      end
      RESP_WAIT: begin
        if (dbus_rvalid) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          bus_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request, write-back and stall outputs; all held low during reset
  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_wdata = '0;
    dbus_be    = '0;
    reg_wr     = 1'b0;
    wdata      = '0;
    mem_stall  = 1'b0;
    if (!rst) begin
      wdata = wb_value;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (!misal) begin
              dbus_req  = 1'b1;
              dbus_we   = cls.is_store;
              dbus_addr = {ALU_ppl[31:2], 2'b00};
              dbus_be   = lane_be;
              if (cls.is_store) begin
                dbus_wdata = st_wdata;
                mem_stall  = ~dbus_ready;
              end else if (dbus_ready && dbus_rvalid) begin
                reg_wr = rd_nz;
              end else begin
                mem_stall = 1'b1;
              end
            end
          end else begin
            reg_wr = cls.writes & rd_nz;
          end
        end
        RESP_WAIT: begin
          if (dbus_rvalid) begin
            reg_wr = rd_nz;
          end else if (!timeout_hit) begin
            mem_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign misalign    = misalign_q;
  assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed vectors with literal expectations plus a
// per-cycle comparison against a transaction-level model of the stage.
module tb_mem_writeback;

  localparam int unsigned TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, alu, rs2, ins, rdat;
  logic        ready, rvalid;
  logic        dbus_req, dbus_we, reg_wr, mem_stall, misalign, bus_timeout;
  logic [31:0] dbus_addr, dbus_wdata, wdata;
  logic [3:0]  dbus_be;

  int total = 0;
  int bad   = 0;

  mem_writeback #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .PC_ppl(pc), .ALU_ppl(alu), .rdata2_ppl(rs2), .instruction_ppl(ins),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ready(ready),
    .dbus_rvalid(rvalid), .dbus_rdata(rdat),
    .reg_wr(reg_wr), .wdata(wdata), .mem_stall(mem_stall),
    .misalign(misalign), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {17'd0, f3, rd, op, 2'b11};
  endfunction

  // Reference load extension: shift the addressed lane down, then extend.
  function automatic logic [31:0] ld_ext(input logic [31:0] word, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> (8 * int'(a));
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_wait = 1'b0;   // a load has been accepted, response pending
  int          m_wait_n = 0;    // RESP_WAIT cycles already spent
  bit          m_mis_q = 1'b0;  // expected registered pulses this cycle
  bit          m_to_q  = 1'b0;

  always @(negedge clk) begin : model
    logic [4:0]  op, rd;
    logic [2:0]  f3;
    bit          is_ld, is_st, writes, nx_mis, nx_to;
    bit          e_req, e_we, e_wr, e_stall;
    logic [31:0] e_addr, e_wd, e_swd;
    logic [3:0]  e_be;
    int          nbytes;
    op = ins[6:2]; rd = ins[11:7]; f3 = ins[14:12];
    is_ld  = (op == 5'd0);
    is_st  = (op == 5'd8);
    writes = (op == 5'd4) || (op == 5'd12) || (op == 5'd13) || (op == 5'd5) ||
             (op == 5'd27) || (op == 5'd25);
    if (is_ld) nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    else       nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    e_req = 0; e_we = 0; e_wr = 0; e_stall = 0; nx_mis = 0; nx_to = 0;
    e_addr = '0; e_wd = '0; e_swd = '0; e_be = '0;
    if (rst) begin
      m_wait = 0;
    end else if (m_wait) begin
      if (rvalid) begin
        e_wr = (rd != 0); e_wd = ld_ext(rdat, alu[1:0], f3); m_wait = 0;
      end else if (TO != 0 && m_wait_n + 1 == int'(TO)) begin
        nx_to = 1; m_wait = 0;
      end else begin
        e_stall = 1; m_wait_n++;
      end
    end else if (is_ld || is_st) begin
      if ((alu % nbytes) != 0) begin
        nx_mis = 1;
      end else begin
        e_req = 1; e_we = is_st; e_addr = alu & ~32'd3;
        if (is_st) begin
          e_swd   = (nbytes == 1) ? rs2[7:0] * 32'h0101_0101 :
                    (nbytes == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
          e_be    = (nbytes == 1) ? 4'(1 << alu[1:0]) :
                    (nbytes == 2) ? 4'(3 << alu[1:0]) : 4'hF;
          e_stall = !ready;
        end else if (ready && rvalid) begin
          e_wr = (rd != 0); e_wd = ld_ext(rdat, alu[1:0], f3);
        end else begin
          e_stall = 1;
          if (ready) begin m_wait = 1; m_wait_n = 0; end
        end
      end
    end else begin
      e_wr = writes && (rd != 0);
      e_wd = (op == 5'd27 || op == 5'd25) ? pc + 32'd4 : alu;
    end

    chk("cyc_req", 32'(dbus_req), 32'(e_req));
    chk("cyc_stall", 32'(mem_stall), 32'(e_stall));
    chk("cyc_regwr", 32'(reg_wr), 32'(e_wr));
    chk("cyc_misalign", 32'(misalign), 32'(m_mis_q));
    chk("cyc_timeout", 32'(bus_timeout), 32'(m_to_q));
    if (e_req) begin
      chk("cyc_we", 32'(dbus_we), 32'(e_we));
      chk("cyc_addr", dbus_addr, e_addr);
      if (e_we) begin
        chk("cyc_swdata", dbus_wdata, e_swd);
        chk("cyc_be", 32'(dbus_be), 32'(e_be));
      end
    end
    if (e_wr) chk("cyc_wdata", wdata, e_wd);
    if (rst) begin
      chk("cyc_rst_addr", dbus_addr, 32'd0);
      chk("cyc_rst_wdata", wdata, 32'd0);
    end
    m_mis_q = nx_mis;
    m_to_q  = nx_to;
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] w, input logic rdy,
                        input logic rv);
    @(posedge clk); #1;
    ins = i; pc = p; alu = a; rs2 = s; rdat = w; ready = rdy; rvalid = rv;
  endtask

  // Load accepted in the first cycle, response k cycles later.
  task automatic run_load(input logic [31:0] i, input logic [31:0] a, input logic [31:0] w,
                          input int k, output int nst, output logic [31:0] wd,
                          output logic wr);
    set_in(i, 32'd0, a, 32'd0, w, 1'b1, k == 0);
    nst = 0;
    for (int c = 0; c <= k; c++) begin
      if (c > 0) begin @(posedge clk); #1; ready = 1'b0; rvalid = (c == k); end
      @(negedge clk);
      nst += int'(mem_stall);
    end
    wd = wdata; wr = reg_wr;
  endtask

  initial begin
    int          nst, hit;
    logic [31:0] wd;
    logic        wr, wr_any;

    rst = 1'b1; ins = NOP; pc = '0; alu = '0; rs2 = '0; rdat = '0;
    ready = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_regwr", 32'(reg_wr), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_timeout", 32'(bus_timeout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ALU and jump write-back
    set_in(mk(5'b00100, 5'd5, 3'd0), 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("addi_wr", 32'(reg_wr), 32'd1);
    chk("addi_wdata", wdata, 32'h1234);
    chk("addi_stall", 32'(mem_stall), 32'd0);
    set_in(mk(5'b00100, 5'd0, 3'd0), 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("addi_x0_wr", 32'(reg_wr), 32'd0);
    set_in(mk(5'b11011, 5'd1, 3'd0), 32'h100, 32'hDEAD, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("jal_wr", 32'(reg_wr), 32'd1);
    chk("jal_wdata", wdata, 32'h104);
    set_in(mk(5'b11000, 5'd3, 3'd0), 32'h200, 32'h1, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("branch_wr", 32'(reg_wr), 32'd0);

    // SB with ready delayed two cycles
    set_in(mk(5'b01000, 5'd0, 3'd0), 32'd0, 32'h1003, 32'hAABBCCDD, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb_wdata", dbus_wdata, 32'hDDDDDDDD);
    chk("sb_be", 32'(dbus_be), 32'h8);
    chk("sb_addr", dbus_addr, 32'h1000);
    chk("sb_we", 32'(dbus_we), 32'd1);
    nst = int'(mem_stall);
    @(posedge clk); #1;
    @(negedge clk); nst += int'(mem_stall);
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk); nst += int'(mem_stall);
    chk("sb_regwr", 32'(reg_wr), 32'd0);
    chk("sb_stalls", 32'(nst), 32'd2);

    // Byte loads with a three-cycle response
    run_load(mk(5'b00000, 5'd7, 3'd0), 32'h2002, 32'h0080_0000, 3, nst, wd, wr);
    chk("lb_stalls", 32'(nst), 32'd3);
    chk("lb_wdata", wd, 32'hFFFFFF80);
    chk("lb_wr", 32'(wr), 32'd1);
    run_load(mk(5'b00000, 5'd7, 3'd4), 32'h2002, 32'h0080_0000, 3, nst, wd, wr);
    chk("lbu_wdata", wd, 32'h0000_0080);

    // Misaligned LW: no request, one misalign pulse
    set_in(mk(5'b00000, 5'd3, 3'd2), 32'd0, 32'h2001, 32'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("mis_req", 32'(dbus_req), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    chk("mis_wr", 32'(reg_wr), 32'd0);
    set_in(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_pulse", 32'(misalign), 32'd1);
    set_in(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mis_pulse_end", 32'(misalign), 32'd0);

    // Halfword/word loads, zero-wait and short waits
    run_load(mk(5'b00000, 5'd4, 3'd1), 32'h2002, 32'h8000_0000, 0, nst, wd, wr);
    chk("lh_stalls", 32'(nst), 32'd0);
    chk("lh_wdata", wd, 32'hFFFF8000);
    run_load(mk(5'b00000, 5'd4, 3'd5), 32'h0010, 32'h1234_F00D, 1, nst, wd, wr);
    chk("lhu_stalls", 32'(nst), 32'd1);
    chk("lhu_wdata", wd, 32'h0000_F00D);
    run_load(mk(5'b00000, 5'd6, 3'd2), 32'h3000, 32'hCAFE_BABE, 2, nst, wd, wr);
    chk("lw_stalls", 32'(nst), 32'd2);
    chk("lw_wdata", wd, 32'hCAFE_BABE);

    // SH / SW lanes
    set_in(mk(5'b01000, 5'd0, 3'd1), 32'd0, 32'h3002, 32'h1234ABCD, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sh_wdata", dbus_wdata, 32'hABCDABCD);
    chk("sh_be", 32'(dbus_be), 32'hC);
    chk("sh_stall", 32'(mem_stall), 32'd0);
    set_in(mk(5'b01000, 5'd0, 3'd2), 32'd0, 32'h3004, 32'h1234ABCD, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sw_be", 32'(dbus_be), 32'hF);
    chk("sw_addr", dbus_addr, 32'h3004);

    // Load accepted, response never arrives
    set_in(mk(5'b00000, 5'd9, 3'd2), 32'd0, 32'h4000, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    nst = int'(mem_stall); hit = 0; wr_any = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      if (bus_timeout) begin hit = c; break; end
      nst += int'(mem_stall);
      wr_any |= reg_wr;
    end
    chk("to_pulse_cycle", 32'(hit), 32'd5);
    chk("to_stalls", 32'(nst), 32'd4);
    chk("to_wr", 32'(wr_any), 32'd0);
    set_in(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset while waiting for a response, then a late rvalid
    set_in(mk(5'b00000, 5'd10, 3'd2), 32'd0, 32'h5000, 32'd0, 32'h1111_2222, 1'b1, 1'b0);
    @(posedge clk); #1 ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstw_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0; rvalid = 1'b1;
    @(negedge clk);
    chk("rstw_wr", 32'(reg_wr), 32'd0);
    chk("rstw_req", 32'(dbus_req), 32'd1);
    chk("rstw_stall_idle", 32'(mem_stall), 32'd1);
    set_in(NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
